count_seq_checker: RTL and testbench

- Receive-side companion to the binary counter: consumes the counter's count stream and checks that consecutive samples increment by exactly one, modulo 2^WIDTH.
- Acquires lock on the stream, then flags every break in sequence and every wrap-around.
- Sits beside the counter in benches and in-system health monitors, and exposes a saturating error tally.

---
 rtl/count_seq_checker_if.sv | 10 +
 rtl/count_seq_checker.sv | 114 +++++++++++
 tb/tb_count_seq_checker.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/count_seq_checker_if.sv
// Count stream from a binary counter into a sequence checker.
interface count_seq_checker_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic [WIDTH-1:0] in_count;

    modport master (output in_valid, output in_count);
    modport slave  (input  in_valid, input  in_count);
endinterface

// File: rtl/count_seq_checker.sv
// Checks that a counter stream increments by one (mod 2^WIDTH), locks onto it,
// and flags sequence breaks and wrap-arounds, with a saturating error tally.
//
// state   | meaning
// --------+---------------------------------------------------------------
// SEARCH  | no reference value yet; next valid sample seeds `expected`
// ACQUIRE | counting consecutive correct increments toward LOCK_COUNT
// LOCKED  | stream trusted; mismatches raise err_pulse, 0 after all-ones wraps
module count_seq_checker #(
    parameter int WIDTH      = 8,
    parameter int LOCK_COUNT = 4,
    parameter int ERR_CNT_W  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    count_seq_checker_if.slave    stream,
    output logic                  locked,
    output logic                  err_pulse,
    output logic                  wrap_pulse,
    output logic [WIDTH-1:0]      expected,
    output logic [ERR_CNT_W-1:0]  err_count
);

    localparam int MC_W = $clog2(LOCK_COUNT + 1);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [MC_W-1:0]      match_cnt_q, match_cnt_d;
    logic [WIDTH-1:0]     expected_d;
    logic [ERR_CNT_W-1:0] err_count_d;
    logic                 err_d, wrap_d;
    logic                 match;

    assign match  = (stream.in_count == expected);
    assign locked = (state_q == LOCKED);

    // State, counters and pulse registers; everything clears asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= SEARCH;
            match_cnt_q <= '0;
            expected    <= '0;
            err_count   <= '0;
            err_pulse   <= 1'b0;
            wrap_pulse  <= 1'b0;
        end else begin
            state_q     <= state_d;
            match_cnt_q <= match_cnt_d;
            expected    <= expected_d;
            err_count   <= err_count_d;
            err_pulse   <= err_d;
            wrap_pulse  <= wrap_d;
        end
    end

    // Next-state, resynchronisation and pulse generation.
    always_comb begin
        state_d     = state_q;
        match_cnt_d = match_cnt_q;
        expected_d  = expected;
        err_count_d = err_count;
        err_d       = 1'b0;
        wrap_d      = 1'b0;

        if (clear) begin
            // Clear keeps the last expected value; only lock and tally restart.
            state_d     = SEARCH;
            match_cnt_d = '0;
            err_count_d = '0;
        end else if (stream.in_valid) begin
            // Always resynchronise to whatever was received.
            expected_d = stream.in_count + WIDTH'(1);
            case (state_q)
                SEARCH: begin
                    state_d     = ACQUIRE;
                    match_cnt_d = '0;
                end
                ACQUIRE: begin
                    if (!match) begin
                        match_cnt_d = '0;
                    end else if (match_cnt_q == MC_W'(LOCK_COUNT - 1)) begin
                        state_d     = LOCKED;
                        match_cnt_d = '0;
                    end else begin
                        match_cnt_d = match_cnt_q + MC_W'(1);
                    end
                end
                LOCKED: begin
                    if (match) begin
                        wrap_d = (stream.in_count == '0);
                    end else begin
                        err_d       = 1'b1;
                        state_d     = ACQUIRE;
                        match_cnt_d = '0;
                        if (err_count != '1) begin
                            err_count_d = err_count + ERR_CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_d     = SEARCH;
                    match_cnt_d = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_count_seq_checker.sv
// Bench for count_seq_checker: directed scenarios then random stream traffic,
// compared against a run-length model of the increment-by-one rules.
module tb_count_seq_checker;

    localparam int LOCK = 4;

    logic       clk;
    logic       reset;
    logic       clear;
    logic       locked8, err8, wrap8;
    logic [7:0] exp8;
    logic [7:0] ec8;
    logic       locked2, err2, wrap2;
    logic [7:0] exp2;
    logic [1:0] ec2;

    count_seq_checker_if #(.WIDTH(8)) strm ();

    count_seq_checker #(.WIDTH(8), .LOCK_COUNT(LOCK), .ERR_CNT_W(8)) dut8 (
        .clk(clk), .reset(reset), .clear(clear), .stream(strm.slave),
        .locked(locked8), .err_pulse(err8), .wrap_pulse(wrap8),
        .expected(exp8), .err_count(ec8)
    );

    count_seq_checker #(.WIDTH(8), .LOCK_COUNT(LOCK), .ERR_CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .clear(clear), .stream(strm.slave),
        .locked(locked2), .err_pulse(err2), .wrap_pulse(wrap2),
        .expected(exp2), .err_count(ec2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: last received value, length of the current unbroken
    // +1 run, whether the run has been long enough to trust.
    logic [7:0] m_prev;
    bit         m_have;
    int         m_run;
    bit         m_lk;
    int         m_ec8, m_ec2;
    bit         m_err, m_wrap;

    task automatic model_reset();
        m_prev = 8'hFF; m_have = 0; m_run = 0; m_lk = 0;
        m_ec8 = 0; m_ec2 = 0; m_err = 0; m_wrap = 0;
    endtask

    task automatic model_update(input bit v, input logic [7:0] c, input bit clr);
        logic [7:0] nxt;
        nxt = m_prev + 8'd1;
        m_err = 0;
        m_wrap = 0;
        if (clr) begin
            m_have = 0; m_lk = 0; m_run = 0; m_ec8 = 0; m_ec2 = 0;
        end else if (v) begin
            if (!m_have) begin
                m_run = 0;
            end else if (c == nxt) begin
                if (m_lk) m_wrap = (c == 8'd0);
                else begin
                    m_run++;
                    if (m_run >= LOCK) m_lk = 1;
                end
            end else begin
                if (m_lk) begin
                    m_err = 1;
                    m_ec8 = (m_ec8 < 255) ? m_ec8 + 1 : 255;
                    m_ec2 = (m_ec2 < 3) ? m_ec2 + 1 : 3;
                end
                m_lk = 0;
                m_run = 0;
            end
            m_prev = c;
            m_have = 1;
        end
    endtask

    function automatic logic [7:0] m_expected();
        return m_prev + 8'd1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        vectors++;
        assert (obs === req) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, req, $time);
        end
    endtask

    task automatic check_all();
        chk("locked",     {31'd0, locked8}, {31'd0, m_lk});
        chk("err_pulse",  {31'd0, err8},    {31'd0, m_err});
        chk("wrap_pulse", {31'd0, wrap8},   {31'd0, m_wrap});
        chk("expected",   {24'd0, exp8},    {24'd0, m_expected()});
        chk("err_count",  {24'd0, ec8},     m_ec8);
        chk("locked_w2",  {31'd0, locked2}, {31'd0, m_lk});
        chk("err_count_w2", {30'd0, ec2},   m_ec2);
    endtask

    task automatic step(input bit v, input logic [7:0] c, input bit clr);
        @(negedge clk);
        strm.in_valid = v;
        strm.in_count = c;
        clear = clr;
        @(posedge clk);
        #1;
        model_update(v, c, clr);
        check_all();
    endtask

    task automatic feed_run(input logic [7:0] start, input int n);
        logic [7:0] val;
        val = start;
        for (int i = 0; i < n; i++) begin
            step(1'b1, val, 1'b0);
            val = val + 8'd1;
        end
    endtask

    initial begin
        logic [7:0] bad;
        logic [7:0] val;
        reset = 1'b0;
        clear = 1'b0;
        strm.in_valid = 1'b0;
        strm.in_count = 8'h00;
        model_reset();
        #1;
        chk("rst_locked", {31'd0, locked8}, 32'd0);
        chk("rst_expected", {24'd0, exp8}, 32'd0);
        chk("rst_err_count", {24'd0, ec8}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Acquisition: 0x10..0x14 locks after the fifth sample.
        feed_run(8'h10, 4);
        chk("acq_not_locked", {31'd0, locked8}, 32'd0);
        step(1'b1, 8'h14, 1'b0);
        chk("acq_locked", {31'd0, locked8}, 32'd1);
        chk("acq_expected", {24'd0, exp8}, 32'h15);

        // Run up to the wrap and through it.
        feed_run(8'h15, 8'hFE - 8'h15);
        feed_run(8'hFE, 2);
        step(1'b1, 8'h00, 1'b0);
        chk("wrap_pulse_hi", {31'd0, wrap8}, 32'd1);
        step(1'b1, 8'h01, 1'b0);
        chk("wrap_pulse_lo", {31'd0, wrap8}, 32'd0);
        chk("wrap_expected", {24'd0, exp8}, 32'h02);

        // Sequence break at expected=0x20, then relock.
        feed_run(8'h02, 8'h20 - 8'h02);
        step(1'b1, 8'h25, 1'b0);
        chk("break_err", {31'd0, err8}, 32'd1);
        chk("break_count", {24'd0, ec8}, 32'd1);
        chk("break_expected", {24'd0, exp8}, 32'h26);
        feed_run(8'h26, 5);
        chk("relock", {31'd0, locked8}, 32'd1);

        // Saturation of the narrow tally after a clear.
        step(1'b1, 8'h55, 1'b1);
        feed_run(8'h60, LOCK + 1);
        for (int i = 0; i < 5; i++) begin
            bad = m_prev + 8'd6;
            step(1'b1, bad, 1'b0);
            chk("sat_err2", {31'd0, err2}, 32'd1);
            chk("sat_count2", {30'd0, ec2}, (i < 3) ? i + 1 : 3);
            feed_run(bad + 8'd1, LOCK);
        end

        // Idle gap while locked, then clear wins over a valid sample.
        step(1'b1, 8'h3B, 1'b0);
        feed_run(8'h3C, 5);
        for (int i = 0; i < 3; i++) step(1'b0, 8'($urandom_range(255)), 1'b0);
        step(1'b1, 8'h41, 1'b0);
        chk("gap_locked", {31'd0, locked8}, 32'd1);
        step(1'b1, 8'h99, 1'b1);
        chk("clr_locked", {31'd0, locked8}, 32'd0);
        chk("clr_expected", {24'd0, exp8}, 32'h42);

        // Asynchronous reset between edges.
        feed_run(8'h42, 6);
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        model_reset();
        chk("arst_locked", {31'd0, locked8}, 32'd0);
        chk("arst_expected", {24'd0, exp8}, 32'd0);
        chk("arst_count", {24'd0, ec8}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        step(1'b1, 8'h07, 1'b0);
        chk("post_rst_expected", {24'd0, exp8}, 32'h08);

        // Random traffic: mostly in-sequence, with gaps, breaks and clears.
        for (int i = 0; i < 3000; i++) begin
            val = ($urandom_range(9) != 0) ? m_expected() : 8'($urandom_range(255));
            step(($urandom_range(4) != 0), val, ($urandom_range(99) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
